// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the load/store request sequencer.
//               - size_e     : access size encoding (byte/half/word/double)
//               - state_e    : sequencer state encoding
//               - size_mask  : byte-enable mask for an access size (lane 0 based)
//               - align_mask : low address bits that must be zero for a size
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Equivalent to (1 << (1 << size)) - 1, written out to keep widths exact.
    function automatic logic [7:0] size_mask(input size_e size);
        logic [7:0] m;
        case (size)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // (1 << size) - 1: any of these address bits set means misaligned.
    function automatic logic [2:0] align_mask(input size_e size);
        logic [2:0] m;
        case (size)
            SZ_B:    m = 3'b000;
            SZ_H:    m = 3'b001;
            SZ_W:    m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_ext
// Description : Combinational load-data extraction. Shifts the 64-bit memory
//               word right by the byte offset, truncates to the access size
//               and sign- or zero-extends back to 64 bits.
// Ports       : i_rdata    [63:0] aligned 64-bit word from memory
//               i_off      [2:0]  byte offset within the word
//               i_size     size_e access size
//               i_unsigned        1 = zero-extend, 0 = sign-extend
//               o_result   [63:0] extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [63:0] i_rdata,
    input  logic [2:0]  i_off,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [63:0] o_result
);

    logic [63:0] w_shifted;

    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_result = '0;
        case (i_size)
            SZ_B:    o_result = {{56{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            SZ_H:    o_result = {{48{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            SZ_W:    o_result = {{32{~i_unsigned & w_shifted[31]}}, w_shifted[31:0]};
            default: o_result = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_req.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_req
// Description : Load/store request sequencer between the memory stage and the
//               memory bridge. One request per handshake, no pipelining.
//               IDLE -> ACCESS -> RESP for aligned accesses, IDLE -> RESP for
//               misaligned ones (flagged with resp_err, no memory access).
// Parameters  : MEM_LAT  cycles mem_en is held for a load (>= 1)
// Ports       : clk, rst              clock / async active-high reset
//               req_valid, req_ready  request handshake
//               req_wen, req_addr, req_wdata, req_size, req_unsigned
//               resp_valid, resp_data, resp_err   one-cycle completion pulse
//               mem_en, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
//               mem_rdata             bridge interface
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_req
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_wen,
    output logic [63:0] mem_raddr,
    output logic [63:0] mem_waddr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata
);

    localparam int                c_CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(MEM_LAT - 1);

    state_e             r_state;
    state_e             w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [63:0]        r_addr;
    logic [63:0]        r_wdata;
    size_e              r_size;
    logic               r_wen;
    logic               r_unsigned;
    logic [63:0]        r_resp_data;
    logic               r_resp_err;

    logic               w_misaligned;
    logic               w_cnt_last;
    logic [63:0]        w_load_data;

    assign w_misaligned = |(req_addr[2:0] & align_mask(size_e'(req_size)));
    assign w_cnt_last   = (r_cnt == c_LAST);
    assign resp_data    = r_resp_data;
    assign resp_err     = r_resp_err;

    lsu_load_ext u_load_ext (
        .i_rdata    (mem_rdata),
        .i_off      (r_addr[2:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_load_data)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and bridge/handshake outputs. All mem_* outputs are zero
    // outside ACCESS so the bridge sees a clean, single-cycle write strobe.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_en       = 1'b0;
        mem_wen      = 1'b0;
        mem_raddr    = '0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        mem_wmask    = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = w_misaligned ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en    = 1'b1;
                mem_wen   = r_wen;
                mem_raddr = {r_addr[63:3], 3'b000};
                mem_waddr = {r_addr[63:3], 3'b000};
                mem_wdata = r_wdata << {r_addr[2:0], 3'b000};
                mem_wmask = size_mask(r_size) << r_addr[2:0];
                // Stores leave after one cycle regardless of MEM_LAT.
                if (r_wen || w_cnt_last) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch, latency counter and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= SZ_B;
            r_wen       <= 1'b0;
            r_unsigned  <= 1'b0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        r_size     <= size_e'(req_size);
                        r_wen      <= req_wen;
                        r_unsigned <= req_unsigned;
                        r_cnt      <= '0;
                        // Misaligned requests skip ACCESS, so the response
                        // is loaded on the way straight into RESP.
                        if (w_misaligned) begin
                            r_resp_data <= '0;
                            r_resp_err  <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_wen) begin
                        r_resp_data <= '0;
                        r_resp_err  <= 1'b0;
                    end else if (w_cnt_last) begin
                        // rdata is only guaranteed on the final held cycle.
                        r_resp_data <= w_load_data;
                        r_resp_err  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_req.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_req
// Description : Scoreboard bench for lsu_mem_req with a small bridge memory
//               model (4 words at 0x80000000). Requests push expected
//               responses and writes; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_req;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        mem_en;
    logic        mem_wen;
    logic [63:0] mem_raddr;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    lsu_mem_req #(.MEM_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_raddr    (mem_raddr),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bridge model ----------------
    logic [63:0] mem [0:3];

    always_comb begin
        mem_rdata = mem_en ? mem[mem_raddr[4:3]] : 64'h0;
    end

    always @(posedge clk) begin
        if (mem_en && mem_wen) begin
            for (int i = 0; i < 8; i++) begin
                if (mem_wmask[i]) mem[mem_waddr[4:3]][8*i +: 8] = mem_wdata[8*i +: 8];
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [63:0] data;
        logic        err;
        int          lat;
        int          men;
        int          acc;
        string       name;
    } resp_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  mask;
        logic [63:0] data;
    } wr_t;

    resp_t respq[$];
    wr_t   wrq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int men_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] lanes(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            men_cnt = 0;
        end else begin
            if (mem_en) men_cnt++;
            if (mem_en && mem_wen) begin
                if (wrq.size() == 0) begin
                    check("unexpected_write", 64'(mem_waddr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wrq.pop_front();
                    check("waddr", mem_waddr, w.addr);
                    check("wmask", 64'(mem_wmask), 64'(w.mask));
                    check("wdata", mem_wdata & lanes(mem_wmask), w.data);
                end
            end
            if (!mem_en) begin
                check("mem_idle_zero", mem_raddr | mem_waddr | mem_wdata | 64'(mem_wmask) | 64'(mem_wen), 64'h0);
            end
            if (resp_valid) begin
                if (respq.size() == 0) begin
                    check("unexpected_resp", resp_data, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    resp_t e;
                    e = respq.pop_front();
                    check({e.name, "_data"},    resp_data, e.data);
                    check({e.name, "_err"},     64'(resp_err), 64'(e.err));
                    check({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
                    check({e.name, "_men_cyc"}, 64'(men_cnt), 64'(e.men));
                end
                men_cnt = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_wr(input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
        wr_t w;
        w.addr = addr; w.mask = mask; w.data = data;
        wrq.push_back(w);
    endtask

    // Called at a negedge; returns at the negedge where req_ready is back.
    task automatic do_req(input string name, input logic wen, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [1:0] size, input logic uns,
                          input logic [63:0] exp_data, input logic exp_err);
        resp_t e;
        int    waited;
        int    gap;
        e.data = exp_data; e.err = exp_err; e.name = name;
        if (exp_err)  begin e.men = 0;   e.lat = 1;       gap = 2;       end
        else if (wen) begin e.men = 1;   e.lat = 2;       gap = 3;       end
        else          begin e.men = LAT; e.lat = LAT + 1; gap = LAT + 2; end
        req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns; req_valid = 1'b1;
        waited = 0;
        while (!req_ready && waited < 50) begin @(negedge clk); waited++; end
        if (!req_ready) begin
            check({name, "_accept_timeout"}, 64'(req_ready), 64'h1);
            req_valid = 1'b0;
            return;
        end
        e.acc = cyc;
        respq.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        waited = 0;
        while (!req_ready && waited < 50) begin @(negedge clk); waited++; end
        check({name, "_ready_gap"}, 64'(cyc - e.acc), 64'(gap));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 64'h0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  64'(req_ready),  64'h1);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_resp_data",  resp_data,       64'h0);
        check("rst_resp_err",   64'(resp_err),   64'h0);
        check("rst_mem_en",     64'(mem_en),     64'h0);
        check("rst_mem_wmask",  64'(mem_wmask),  64'h0);
        rst = 1'b0;
        @(negedge clk);

        // Byte store into lane 3, then read it back signed and unsigned.
        push_wr(64'h8000_0000, 8'h08, 64'h0000_0000_AB00_0000);
        do_req("sb",  1'b1, 64'h8000_0003, 64'h1122_3344_5566_77AB, 2'd0, 1'b0, 64'h0, 1'b0);
        do_req("lb",  1'b0, 64'h8000_0003, 64'h0, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, 1'b0);
        do_req("lbu", 1'b0, 64'h8000_0003, 64'h0, 2'd0, 1'b1, 64'h0000_0000_0000_00AB, 1'b0);

        mem[0] = 64'h8000_0000_1234_5678;
        do_req("lw",  1'b0, 64'h8000_0004, 64'h0, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);
        do_req("lwu", 1'b0, 64'h8000_0000, 64'h0, 2'd2, 1'b1, 64'h0000_0000_1234_5678, 1'b0);

        mem[0] = 64'hBEEF_0000_0000_0000;
        do_req("lhu", 1'b0, 64'h8000_0006, 64'h0, 2'd1, 1'b1, 64'h0000_0000_0000_BEEF, 1'b0);
        do_req("lh",  1'b0, 64'h8000_0006, 64'h0, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0);

        // Misaligned accesses: error response, no memory traffic.
        do_req("sw_mis", 1'b1, 64'h8000_0002, 64'h5555_5555, 2'd2, 1'b0, 64'h0, 1'b1);
        do_req("ld_mis", 1'b0, 64'h8000_0004, 64'h0, 2'd3, 1'b0, 64'h0, 1'b1);
        do_req("sh_mis", 1'b1, 64'h8000_0001, 64'h1234, 2'd1, 1'b0, 64'h0, 1'b1);

        // Back-to-back store/load through the bridge model.
        push_wr(64'h8000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF);
        do_req("sd", 1'b1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 64'h0, 1'b0);
        do_req("ld", 1'b0, 64'h8000_0008, 64'h0, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);

        push_wr(64'h8000_0010, 8'hC0, 64'h1234_0000_0000_0000);
        do_req("sh",   1'b1, 64'h8000_0016, 64'hFFFF_1234, 2'd1, 1'b0, 64'h0, 1'b0);
        do_req("ld_h", 1'b0, 64'h8000_0010, 64'h0, 2'd3, 1'b0, 64'h1234_0000_0000_0000, 1'b0);

        // Reset in the middle of a load's ACCESS phase.
        req_wen = 1'b0; req_addr = 64'h8000_0000; req_size = 2'd2;
        req_unsigned = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("rstmid_in_access", 64'(mem_en), 64'h1);
        rst = 1'b1;
        #1;
        check("rstmid_req_ready",  64'(req_ready),  64'h1);
        check("rstmid_resp_valid", 64'(resp_valid), 64'h0);
        check("rstmid_mem_en",     64'(mem_en),     64'h0);
        check("rstmid_mem_raddr",  mem_raddr,       64'h0);
        check("rstmid_resp_data",  resp_data,       64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_req("lwu_after_rst", 1'b0, 64'h8000_0004, 64'h0, 2'd2, 1'b1, 64'h0000_0000_BEEF_0000, 1'b0);

        repeat (4) @(negedge clk);
        check("resp_queue_empty",  64'(respq.size()), 64'h0);
        check("write_queue_empty", 64'(wrq.size()),   64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
